// File: rtl/led_matrix_pkg.sv
// Shared defaults and index-width helper for the LED matrix column scanner.
package led_matrix_pkg;

    localparam int unsigned DEF_ROWS     = 7;
    localparam int unsigned DEF_COLS     = 5;
    localparam int unsigned DEF_CH       = 2;
    localparam int unsigned DEF_SCAN_DIV = 1000;
    localparam int unsigned DEF_BLANK    = 1;
    localparam int unsigned DEF_DWELL    = 50;

    // Width needed to index n items, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_matrix_scan_tick_divider.sv
// Free-running prescaler: counts 0..DIV-1 and flags the terminal count.
module tick_divider
    import led_matrix_pkg::*;
#(
    parameter  int unsigned DIV  = DEF_SCAN_DIV,
    localparam int unsigned CNTW = idx_width(DIV)
)(
    input  logic            clk,
    input  logic            rst_n,
    output logic [CNTW-1:0] count,
    output logic            tick
);

    assign tick = (32'(count) == DIV - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/led_matrix_scan.sv
// Column-multiplexed LED matrix driver with blanking and manual/auto channel selection.
module led_matrix_scan
    import led_matrix_pkg::*;
#(
    parameter  int unsigned ROWS     = DEF_ROWS,
    parameter  int unsigned COLS     = DEF_COLS,
    parameter  int unsigned CH       = DEF_CH,
    parameter  int unsigned SCAN_DIV = DEF_SCAN_DIV,
    parameter  int unsigned BLANK    = DEF_BLANK,
    parameter  int unsigned DWELL    = DEF_DWELL,
    localparam int unsigned CW       = idx_width(CH)
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CH*COLS*ROWS-1:0] frame_in,
    input  logic [CW-1:0]           sel,
    input  logic                    auto_en,
    output logic [ROWS-1:0]         rows,
    output logic [COLS-1:0]         col_en,
    output logic [CW-1:0]           active_ch,
    output logic                    frame_start
);

    localparam int unsigned PW   = idx_width(SCAN_DIV);
    localparam int unsigned COLW = idx_width(COLS);
    localparam int unsigned DW   = idx_width(DWELL);

    logic [PW-1:0]   pre_count;
    logic            tick;
    logic [COLW-1:0] col;
    logic [DW-1:0]   dwell;
    logic            auto_q;
    logic            running;

    logic            boundary;
    logic [COLW-1:0] col_nx;
    logic [COLW-1:0] col_sel;
    logic [PW-1:0]   count_nx;
    logic [CW-1:0]   ch_nx;
    logic [DW-1:0]   dwell_nx;
    logic [ROWS-1:0] slice;
    logic [COLS-1:0] col_en_nx;
    int unsigned     slice_base;

    tick_divider #(.DIV(SCAN_DIV)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .count (pre_count),
        .tick  (tick)
    );

    always_comb begin
        boundary = tick && (32'(col) == COLS - 1);
        col_nx   = boundary ? '0 : col + 1'b1;
        col_sel  = tick ? col_nx : col;
        count_nx = tick ? '0 : pre_count + 1'b1;
        ch_nx    = active_ch;
        dwell_nx = dwell;

        // A fresh 0->1 auto transition behaves like a manual load: sel seeds the rotation.
        if (boundary) begin
            if (!auto_en || !auto_q) begin
                if (32'(sel) < CH) ch_nx = sel;
                dwell_nx = '0;
            end else if (32'(dwell) == DWELL - 1) begin
                dwell_nx = '0;
                ch_nx    = (32'(active_ch) == CH - 1) ? '0 : active_ch + 1'b1;
            end else begin
                dwell_nx = dwell + 1'b1;
            end
        end

        slice_base = (32'(ch_nx) * COLS + 32'(col_nx)) * ROWS;
        slice      = ROWS'(frame_in >> slice_base);

        // Columns stay dark until the first slot has been loaded after reset.
        col_en_nx = '0;
        if ((running || tick) && (32'(count_nx) >= BLANK)) begin
            col_en_nx = COLS'(1) << col_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col         <= COLW'(COLS - 1);
            dwell       <= '0;
            auto_q      <= 1'b0;
            running     <= 1'b0;
            active_ch   <= '0;
            rows        <= '0;
            col_en      <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= boundary;
            col_en      <= col_en_nx;
            if (tick) begin
                col       <= col_nx;
                rows      <= slice;
                active_ch <= ch_nx;
                dwell     <= dwell_nx;
                running   <= 1'b1;
            end
            if (boundary) auto_q <= auto_en;
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Scoreboard bench for led_matrix_scan: timing, manual/auto channels, reset and patterns.
module tb_led_matrix_scan;

    localparam int unsigned ROWS     = 7;
    localparam int unsigned COLS     = 5;
    localparam int unsigned CH       = 2;
    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned BLANK    = 1;
    localparam int unsigned DWELL    = 2;
    localparam int unsigned FW       = CH * COLS * ROWS;
    localparam int unsigned FW3      = 3 * COLS * ROWS;

    typedef struct packed {
        logic [ROWS-1:0] rows;
        logic [COLS-1:0] col_en;
        logic            fs;
        logic [0:0]      ch;
    } obs_t;

    typedef struct packed {
        logic [ROWS-1:0] rows;
        logic [1:0]      ch;
    } obs3_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [FW-1:0]   frame_in = '0;
    logic [0:0]      sel = '0;
    logic            auto_en = 1'b0;
    logic [ROWS-1:0] rows;
    logic [COLS-1:0] col_en;
    logic [0:0]      active_ch;
    logic            frame_start;

    logic [FW3-1:0]  frame_in3 = '0;
    logic [1:0]      sel3 = '0;
    logic [ROWS-1:0] rows3;
    logic [COLS-1:0] col_en3;
    logic [1:0]      active_ch3;
    logic            frame_start3;

    obs_t  obs;
    obs3_t obs3;
    obs_t  sb[$];
    obs3_t sb3[$];

    int tests = 0;
    int fails = 0;

    assign obs  = {rows, col_en, frame_start, active_ch};
    assign obs3 = {rows3, active_ch3};

    always #5 clk = ~clk;

    led_matrix_scan #(
        .ROWS(ROWS), .COLS(COLS), .CH(CH), .SCAN_DIV(SCAN_DIV), .BLANK(BLANK), .DWELL(DWELL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_in(frame_in), .sel(sel), .auto_en(auto_en),
        .rows(rows), .col_en(col_en), .active_ch(active_ch), .frame_start(frame_start)
    );

    led_matrix_scan #(
        .ROWS(ROWS), .COLS(COLS), .CH(3), .SCAN_DIV(SCAN_DIV), .BLANK(BLANK), .DWELL(DWELL)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .frame_in(frame_in3), .sel(sel3), .auto_en(1'b0),
        .rows(rows3), .col_en(col_en3), .active_ch(active_ch3), .frame_start(frame_start3)
    );

    // n counts clock edges since reset release; the first slot loads at edge SCAN_DIV.
    function automatic int unsigned frame_of(input int unsigned n);
        return (n < SCAN_DIV) ? 0 : (n / SCAN_DIV - 1) / COLS;
    endfunction

    function automatic obs_t expect_at(input int unsigned n, input int unsigned ch,
                                       input logic [FW-1:0] fr);
        obs_t e;
        int unsigned c;
        e = '0;
        if (n < SCAN_DIV) return e;
        c = (n / SCAN_DIV - 1) % COLS;
        e.ch = 1'(ch);
        for (int unsigned r = 0; r < ROWS; r++) e.rows[r] = fr[(ch * COLS + c) * ROWS + r];
        if ((n % SCAN_DIV) >= BLANK) e.col_en[c] = 1'b1;
        e.fs = ((n % SCAN_DIV) == 0) && (c == 0);
        return e;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        frame_in  = FW'({$urandom(), $urandom(), $urandom()});
        frame_in3 = FW3'({$urandom(), $urandom(), $urandom(), $urandom()});
        sel = 1'b1; sel3 = 2'd2; auto_en = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (obs !== '0) begin
            fails++;
            $display("FAIL reset_main: got %h, expected 0", obs);
        end
        tests++;
        if ({obs3, col_en3, frame_start3} !== '0) begin
            fails++;
            $display("FAIL reset_ch3: got rows=%b col_en=%b fs=%b ch=%0d, expected all 0",
                     rows3, col_en3, frame_start3, active_ch3);
        end
    endtask

    task automatic test_scan_timing();
        obs_t e;
        frame_in = FW'({$urandom(), $urandom(), $urandom()});
        sel = 1'b0; auto_en = 1'b0;
        apply_reset();
        rst_n = 1'b1;
        for (int unsigned n = 1; n <= 45; n++) begin
            sb.push_back(expect_at(n, 0, frame_in));
            @(posedge clk); #1;
            e = sb.pop_front();
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL scan_timing n=%0d: got rows=%b col_en=%b fs=%b ch=%0d, expected rows=%b col_en=%b fs=%b ch=%0d",
                         n, rows, col_en, frame_start, active_ch, e.rows, e.col_en, e.fs, e.ch);
            end
        end
    endtask

    task automatic test_manual_switch();
        obs_t e;
        frame_in = '0;
        frame_in[COLS*ROWS-1:0] = '1;
        sel = 1'b0; auto_en = 1'b0;
        apply_reset();
        rst_n = 1'b1;
        for (int unsigned n = 1; n <= 40; n++) begin
            if (n == 13) sel = 1'b1;
            sb.push_back(expect_at(n, (frame_of(n) == 0) ? 0 : 1, frame_in));
            @(posedge clk); #1;
            e = sb.pop_front();
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL manual_switch n=%0d: got rows=%b col_en=%b fs=%b ch=%0d, expected rows=%b col_en=%b fs=%b ch=%0d",
                         n, rows, col_en, frame_start, active_ch, e.rows, e.col_en, e.fs, e.ch);
            end
        end
    endtask

    task automatic test_auto_rotation();
        obs_t e;
        int unsigned seq [5] = '{0, 0, 1, 1, 0};
        frame_in = FW'({$urandom(), $urandom(), $urandom()});
        sel = 1'b0; auto_en = 1'b1;
        apply_reset();
        rst_n = 1'b1;
        for (int unsigned n = 1; n <= 103; n++) begin
            if (n == 50) sel = 1'b1;
            sb.push_back(expect_at(n, seq[frame_of(n)], frame_in));
            @(posedge clk); #1;
            e = sb.pop_front();
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL auto_rotation n=%0d: got rows=%b col_en=%b fs=%b ch=%0d, expected rows=%b col_en=%b fs=%b ch=%0d",
                         n, rows, col_en, frame_start, active_ch, e.rows, e.col_en, e.fs, e.ch);
            end
        end
        auto_en = 1'b0;
    endtask

    task automatic test_sel_out_of_range();
        obs3_t e;
        int unsigned ch, c;
        frame_in3 = FW3'({$urandom(), $urandom(), $urandom(), $urandom()});
        sel3 = 2'd1;
        apply_reset();
        rst_n = 1'b1;
        for (int unsigned n = 1; n <= 52; n++) begin
            if (n == 12) sel3 = 2'd3;
            if (n == 32) sel3 = 2'd2;
            e = '0;
            if (n >= SCAN_DIV) begin
                ch = (frame_of(n) < 2) ? 1 : 2;
                c  = (n / SCAN_DIV - 1) % COLS;
                e.ch = 2'(ch);
                for (int unsigned r = 0; r < ROWS; r++) e.rows[r] = frame_in3[(ch * COLS + c) * ROWS + r];
            end
            sb3.push_back(e);
            @(posedge clk); #1;
            e = sb3.pop_front();
            tests++;
            if (obs3 !== e) begin
                fails++;
                $display("FAIL sel_range n=%0d: got rows=%b ch=%0d, expected rows=%b ch=%0d",
                         n, rows3, active_ch3, e.rows, e.ch);
            end
        end
    endtask

    task automatic test_mid_reset();
        obs_t e;
        frame_in = FW'({$urandom(), $urandom(), $urandom()});
        sel = 1'b0; auto_en = 1'b0;
        apply_reset();
        rst_n = 1'b1;
        for (int unsigned n = 1; n <= 17; n++) begin
            sb.push_back(expect_at(n, 0, frame_in));
            @(posedge clk); #1;
            e = sb.pop_front();
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL mid_reset_pre n=%0d: got %h, expected %h", n, obs, e);
            end
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (obs !== '0) begin
            fails++;
            $display("FAIL mid_reset_clear: got %h, expected 0", obs);
        end
        rst_n = 1'b1;
        for (int unsigned n = 1; n <= 30; n++) begin
            sb.push_back(expect_at(n, 0, frame_in));
            @(posedge clk); #1;
            e = sb.pop_front();
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL mid_reset_restart n=%0d: got rows=%b col_en=%b fs=%b ch=%0d, expected rows=%b col_en=%b fs=%b ch=%0d",
                         n, rows, col_en, frame_start, active_ch, e.rows, e.col_en, e.fs, e.ch);
            end
        end
    endtask

    task automatic test_checkerboard();
        obs_t e;
        for (int unsigned c = 0; c < COLS; c++) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                frame_in[c * ROWS + r]          = 1'b1;
                frame_in[(COLS + c) * ROWS + r] = ((r + c) % 2) == 1;
            end
        end
        sel = 1'b1; auto_en = 1'b0;
        apply_reset();
        rst_n = 1'b1;
        for (int unsigned n = 1; n <= 45; n++) begin
            sb.push_back(expect_at(n, (n < SCAN_DIV) ? 0 : 1, frame_in));
            @(posedge clk); #1;
            e = sb.pop_front();
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL checkerboard n=%0d: got rows=%b col_en=%b fs=%b ch=%0d, expected rows=%b col_en=%b fs=%b ch=%0d",
                         n, rows, col_en, frame_start, active_ch, e.rows, e.col_en, e.fs, e.ch);
            end
            tests++;
            if (!$onehot0(col_en)) begin
                fails++;
                $display("FAIL col_onehot n=%0d: got col_en=%b, expected one-hot or zero", n, col_en);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_timing();
        test_manual_switch();
        test_auto_rotation();
        test_sel_out_of_range();
        test_mid_reset();
        test_checkerboard();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
